// File: rtl/timer_pkg.sv
// Shared constants for the programmable timer/counter blocks.
package timer_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_PRESCALE_W = 4;
  localparam int DEF_RESET_VAL  = 0;

endpackage

// File: rtl/prog_counter_if.sv
// Control/status bundle of the programmable counter; master drives controls, slave is the counter.
interface prog_counter_if #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
);
  logic                  en;
  logic                  up_dn;
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic [WIDTH-1:0]      modulo;
  logic                  sat_mode;
  logic [PRESCALE_W-1:0] prescale;
  logic                  clr_ovf;
  logic [WIDTH-1:0]      cnt;
  logic                  tc;
  logic                  ovf;

  modport master (
    output en, up_dn, load, load_val, modulo, sat_mode, prescale, clr_ovf,
    input  cnt, tc, ovf
  );

  modport slave (
    input  en, up_dn, load, load_val, modulo, sat_mode, prescale, clr_ovf,
    output cnt, tc, ovf
  );
endinterface

// File: rtl/prog_counter_prescaler.sv
// Clock-enable divider: emits one tick every prescale+1 enabled cycles.
module prog_counter_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pre_cnt_reg;
  logic [PRESCALE_W-1:0] pre_cnt_next;

  // >= compare so that shrinking prescale below pre_cnt ticks right away
  assign tick = en & (pre_cnt_reg >= prescale);

  always_comb begin
    pre_cnt_next = pre_cnt_reg;
    if (clear) begin
      pre_cnt_next = '0;
    end else if (en) begin
      pre_cnt_next = tick ? '0 : pre_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt_reg <= '0;
    end else begin
      pre_cnt_reg <= pre_cnt_next;
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with prescaler, load, modulo bound, wrap/saturate,
// terminal-count pulse and sticky overflow flag.
module prog_counter
  import timer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W,
  parameter int RESET_VAL  = DEF_RESET_VAL
) (
  input logic           clk,
  input logic           reset,
  prog_counter_if.slave bus
);

  logic             tick;
  logic             boundary;
  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] cnt_next;
  logic             tc_reg;
  logic             tc_next;
  logic             ovf_reg;
  logic             ovf_next;

  prog_counter_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en       (bus.en),
    .clear    (bus.load),
    .prescale (bus.prescale),
    .tick     (tick)
  );

  always_comb begin
    cnt_next = cnt_reg;
    boundary = 1'b0;
    if (bus.load) begin
      cnt_next = (bus.load_val > bus.modulo) ? bus.modulo : bus.load_val;
    end else if (tick) begin
      if (bus.up_dn == DIR_UP) begin
        if (cnt_reg < bus.modulo) begin
          cnt_next = cnt_reg + 1'b1;
        end else begin
          boundary = 1'b1;
          cnt_next = (bus.sat_mode == MODE_SAT) ? bus.modulo : '0;
        end
      end else begin
        // A run-time modulo reduction pulls the count back into range silently
        if (cnt_reg > bus.modulo) begin
          cnt_next = bus.modulo;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          boundary = 1'b1;
          cnt_next = (bus.sat_mode == MODE_SAT) ? '0 : bus.modulo;
        end
      end
    end
    tc_next  = boundary;
    ovf_next = boundary | (ovf_reg & ~bus.clr_ovf);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= WIDTH'(RESET_VAL);
      tc_reg  <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      tc_reg  <= tc_next;
      ovf_reg <= ovf_next;
    end
  end

  assign bus.cnt = cnt_reg;
  assign bus.tc  = tc_reg;
  assign bus.ovf = ovf_reg;

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter: formula-driven long runs plus a vector table.
module tb_prog_counter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  prog_counter_if #(.WIDTH(8), .PRESCALE_W(4)) bus ();

  prog_counter #(
    .WIDTH      (8),
    .PRESCALE_W (4),
    .RESET_VAL  (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [7:0] cnt;
    logic       tc;
    logic       ovf;
    string      name;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       en;
    logic       up;
    logic       ld;
    logic [7:0] lv;
    logic [7:0] md;
    logic       sat;
    logic [3:0] ps;
    logic       clr;
    logic [7:0] ec;
    logic       et;
    logic       eo;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void add(input logic rst, input logic en, input logic up, input logic ld,
                              input logic [7:0] lv, input logic [7:0] md, input logic sat,
                              input logic [3:0] ps, input logic clr,
                              input logic [7:0] ec, input logic et, input logic eo);
    vec_t v;
    v = '{rst, en, up, ld, lv, md, sat, ps, clr, ec, et, eo};
    vecs.push_back(v);
  endfunction

  // Inputs are already applied; queue the expectation, let one edge pass, then compare.
  task automatic edge_check(input string nm, input logic [7:0] ec, input logic et, input logic eo);
    exp_t e;
    e.cnt = ec; e.tc = et; e.ovf = eo; e.name = nm;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks += 3;
    if (bus.cnt !== e.cnt) begin
      errors++;
      $display("FAIL %s cnt: got %0d expected %0d", e.name, bus.cnt, e.cnt);
    end
    if (bus.tc !== e.tc) begin
      errors++;
      $display("FAIL %s tc: got %b expected %b", e.name, bus.tc, e.tc);
    end
    if (bus.ovf !== e.ovf) begin
      errors++;
      $display("FAIL %s ovf: got %b expected %b", e.name, bus.ovf, e.ovf);
    end
    $display("%s: cnt=%0d tc=%b ovf=%b", e.name, bus.cnt, bus.tc, bus.ovf);
  endtask

  task automatic set_in(input logic en, input logic up, input logic ld, input logic [7:0] lv,
                        input logic [7:0] md, input logic sat, input logic [3:0] ps, input logic clr);
    bus.en = en; bus.up_dn = up; bus.load = ld; bus.load_val = lv;
    bus.modulo = md; bus.sat_mode = sat; bus.prescale = ps; bus.clr_ovf = clr;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, 8'd0, 8'd255, 1'b0, 4'd0, 1'b0);
    @(posedge clk);
    #1;
    edge_check("reset", 8'd0, 1'b0, 1'b0);

    // Free-running defaults: cnt = j mod 256, one tc at the 255 -> 0 wrap
    reset = 1'b0;
    for (int j = 1; j <= 300; j++)
      edge_check($sformatf("free[%0d]", j), 8'(j % 256), j == 256, j >= 256);

    // prescale=3, modulo=9: one step every 4 cycles, wrap at step 10
    reset = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, 8'd0, 8'd9, 1'b0, 4'd3, 1'b0);
    edge_check("pre_reset", 8'd0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int j = 1; j <= 44; j++)
      edge_check($sformatf("pre[%0d]", j), 8'((j / 4) % 10), j == 40, j >= 40);
    // en low for 5 cycles stretches the 4-cycle interval to 9
    for (int k = 1; k <= 9; k++) begin
      bus.en = !(k >= 3 && k <= 7);
      edge_check($sformatf("stretch[%0d]", k), (k == 9) ? 8'd2 : 8'd1, 1'b0, 1'b1);
    end

    // rst en up ld lv md sat ps clr | cnt tc ovf
    // Saturate up at 5, then down to 0 and hold
    add(1,1,1,0,  0,  5,1,0,0,   0,0,0);
    for (int i = 1; i <= 5; i++) add(0,1,1,0,0,5,1,0,0, 8'(i),0,0);
    add(0,1,1,0,  0,  5,1,0,0,   5,1,1);
    add(0,1,1,0,  0,  5,1,0,0,   5,1,1);
    for (int i = 4; i >= 0; i--) add(0,1,0,0,0,5,1,0,0, 8'(i),0,1);
    add(0,1,0,0,  0,  5,1,0,0,   0,1,1);
    add(0,1,0,0,  0,  5,1,0,0,   0,1,1);
    // Load clamps to modulo and restarts the prescaler
    add(0,1,1,1,200,100,0,2,0, 100,0,1);
    add(0,1,1,0,  0,100,0,2,0, 100,0,1);
    add(0,1,1,0,  0,100,0,2,0, 100,0,1);
    add(0,1,1,0,  0,100,0,2,0,   0,1,1);
    add(0,1,0,0,  0,100,0,2,0,   0,0,1);
    add(0,1,0,0,  0,100,0,2,0,   0,0,1);
    add(0,1,0,1,  7,100,0,2,0,   7,0,1);
    add(0,1,0,0,  0,100,0,2,0,   7,0,1);
    add(0,1,0,0,  0,100,0,2,0,   7,0,1);
    add(0,1,0,0,  0,100,0,2,0,   6,0,1);
    // Sticky flag clear, clear coincident with wrap, reset mid-prescale
    add(0,0,0,0,  0,100,0,2,1,   6,0,0);
    add(0,1,1,0,  0,  6,0,0,1,   0,1,1);
    add(0,1,1,1,  7, 20,0,3,0,   7,0,1);
    add(0,1,1,0,  0, 20,0,3,0,   7,0,1);
    add(0,1,1,0,  0, 20,0,3,0,   7,0,1);
    add(1,1,1,0,  0, 20,0,3,0,   0,0,0);
    add(0,1,1,0,  0, 20,0,3,0,   0,0,0);
    add(0,1,1,0,  0, 20,0,3,0,   0,0,0);
    add(0,1,1,0,  0, 20,0,3,0,   0,0,0);
    add(0,1,1,0,  0, 20,0,3,0,   1,0,0);
    // Down wrap at modulo=3, run-time modulo reduction, modulo=0
    add(0,1,0,0,  0,  3,0,0,0,   0,0,0);
    add(0,1,0,0,  0,  3,0,0,0,   3,1,1);
    add(0,1,0,0,  0,  3,0,0,0,   2,0,1);
    add(0,1,0,0,  0,  3,0,0,0,   1,0,1);
    add(0,1,0,0,  0,  3,0,0,0,   0,0,1);
    add(0,1,0,0,  0,  3,0,0,0,   3,1,1);
    add(0,1,0,0,  0,  1,0,0,0,   1,0,1);
    add(0,1,0,0,  0,  1,0,0,0,   0,0,1);
    add(0,1,0,0,  0,  1,0,0,0,   1,1,1);
    add(0,1,0,0,  0,  0,0,0,0,   0,0,1);
    add(0,1,0,0,  0,  0,0,0,0,   0,1,1);
    add(0,1,1,0,  0,  0,0,0,0,   0,1,1);
    add(0,0,1,0,  0,  0,0,0,1,   0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst;
      set_in(vecs[i].en, vecs[i].up, vecs[i].ld, vecs[i].lv,
             vecs[i].md, vecs[i].sat, vecs[i].ps, vecs[i].clr);
      edge_check($sformatf("vec[%0d]", i), vecs[i].ec, vecs[i].et, vecs[i].eo);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
